// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the ID-stage pipeline control: opcodes, control-word
// bit positions, per-class control words and the stall FSM state type.
package pipe_ctrl_pkg;

  localparam int unsigned OPC_W       = 6;
  localparam int unsigned CW_W        = 8;
  localparam int unsigned STALL_CNT_W = 3;

  localparam logic [OPC_W-1:0] OPC_R    = 6'b000000;
  localparam logic [OPC_W-1:0] OPC_LW   = 6'b100011;
  localparam logic [OPC_W-1:0] OPC_SW   = 6'b101011;
  localparam logic [OPC_W-1:0] OPC_BEQ  = 6'b000100;
  localparam logic [OPC_W-1:0] OPC_BNE  = 6'b000101;
  localparam logic [OPC_W-1:0] OPC_ADDI = 6'b001000;
  localparam logic [OPC_W-1:0] OPC_J    = 6'b000010;

  // Word layout {RegWrite,MemtoReg,MemRead,MemWrite,ALUSrc,ALUOp[1:0],RegDst}
  localparam int unsigned CB_REG_WRITE  = 7;
  localparam int unsigned CB_MEM_TO_REG = 6;
  localparam int unsigned CB_MEM_READ   = 5;
  localparam int unsigned CB_MEM_WRITE  = 4;
  localparam int unsigned CB_ALU_SRC    = 3;
  localparam int unsigned CB_ALU_OP_LO  = 1;
  localparam int unsigned CB_REG_DST    = 0;

  localparam logic [CW_W-1:0] CW_NOP  = '0;
  localparam logic [CW_W-1:0] CW_R    = CW_W'((1 << CB_REG_WRITE) | (2 << CB_ALU_OP_LO) |
                                              (1 << CB_REG_DST));
  localparam logic [CW_W-1:0] CW_LW   = CW_W'((1 << CB_REG_WRITE) | (1 << CB_MEM_TO_REG) |
                                              (1 << CB_MEM_READ) | (1 << CB_ALU_SRC));
  localparam logic [CW_W-1:0] CW_SW   = CW_W'((1 << CB_MEM_WRITE) | (1 << CB_ALU_SRC));
  localparam logic [CW_W-1:0] CW_BR   = CW_W'(1 << CB_ALU_OP_LO);
  localparam logic [CW_W-1:0] CW_ADDI = CW_W'((1 << CB_REG_WRITE) | (1 << CB_ALU_SRC));
  localparam logic [CW_W-1:0] CW_J    = CW_NOP;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// ID-stage control bus: decode/hazard inputs and the control/enable outputs.
interface pipe_ctrl_if #(
  parameter int unsigned OP_W  = 6,
  parameter int unsigned RA_W  = 5,
  parameter int unsigned CNT_W = 8
) ();
  import pipe_ctrl_pkg::*;

  logic              valid_i;
  logic [OP_W-1:0]   op_i;
  logic [RA_W-1:0]   rs_i;
  logic [RA_W-1:0]   rt_i;
  logic              ex_memread_i;
  logic [RA_W-1:0]   ex_rt_i;
  logic              br_eq_i;
  logic              hold_i;

  logic [CW_W-1:0]   ctrl_o;
  logic              ctrl_valid_o;
  logic              pc_write_o;
  logic              ifid_write_o;
  logic              ifid_flush_o;
  logic              jump_o;
  logic              branch_o;
  logic              illegal_o;
  logic [CNT_W-1:0]  illegal_cnt_o;

  modport master (
    output valid_i, op_i, rs_i, rt_i, ex_memread_i, ex_rt_i, br_eq_i, hold_i,
    input  ctrl_o, ctrl_valid_o, pc_write_o, ifid_write_o, ifid_flush_o,
           jump_o, branch_o, illegal_o, illegal_cnt_o
  );

  modport slave (
    input  valid_i, op_i, rs_i, rt_i, ex_memread_i, ex_rt_i, br_eq_i, hold_i,
    output ctrl_o, ctrl_valid_o, pc_write_o, ifid_write_o, ifid_flush_o,
           jump_o, branch_o, illegal_o, illegal_cnt_o
  );

endinterface

// File: rtl/pipe_ctrl_decode.sv
// Combinational opcode decoder: control word, legality and instruction class flags.
module pipe_ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned OP_W   = 6,
  parameter bit          EN_EXT = 1'b1
) (
  input  logic [OP_W-1:0] op_i,
  output logic [CW_W-1:0] word_c,
  output logic            legal_c,
  output logic            uses_rt_c,
  output logic            is_beq_c,
  output logic            is_bne_c,
  output logic            is_j_c
);

  // Extended opcodes fall through to illegal (word 0) when EN_EXT is clear.
  always_comb begin
    word_c    = CW_NOP;
    legal_c   = 1'b0;
    uses_rt_c = 1'b0;
    is_beq_c  = 1'b0;
    is_bne_c  = 1'b0;
    is_j_c    = 1'b0;
    case (op_i)
      OP_W'(OPC_R):    begin word_c = CW_R;  legal_c = 1'b1; uses_rt_c = 1'b1; end
      OP_W'(OPC_LW):   begin word_c = CW_LW; legal_c = 1'b1; end
      OP_W'(OPC_SW):   begin word_c = CW_SW; legal_c = 1'b1; uses_rt_c = 1'b1; end
      OP_W'(OPC_BEQ):  begin word_c = CW_BR; legal_c = 1'b1; uses_rt_c = 1'b1; is_beq_c = 1'b1; end
      OP_W'(OPC_BNE): begin
        uses_rt_c = 1'b1;
        if (EN_EXT) begin word_c = CW_BR; legal_c = 1'b1; is_bne_c = 1'b1; end
      end
      OP_W'(OPC_ADDI): if (EN_EXT) begin word_c = CW_ADDI; legal_c = 1'b1; end
      OP_W'(OPC_J):    if (EN_EXT) begin word_c = CW_J;    legal_c = 1'b1; is_j_c = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// ID-stage control: registers the decoded ID/EX word, inserts load-use bubbles,
// drives PC / IF-ID enables and branch/jump flush, counts illegal opcodes.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned OP_W         = 6,
  parameter int unsigned RA_W         = 5,
  parameter int unsigned STALL_CYCLES = 1,
  parameter int unsigned CNT_W        = 8,
  parameter bit          EN_EXT       = 1'b1
) (
  input logic        clk_i,
  input logic        rst_i,
  pipe_ctrl_if.slave bus
);

  state_e                 state_q, state_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CW_W-1:0]        ctrl_q, ctrl_d;
  logic                   ctrl_valid_q, ctrl_valid_d;
  logic                   illegal_q, illegal_d;
  logic [CNT_W-1:0]       illegal_cnt_q, illegal_cnt_d;

  logic [CW_W-1:0] word_c;
  logic            legal_c, uses_rt_c, is_beq_c, is_bne_c, is_j_c;
  logic            hazard_c;
  logic            pc_write_c, branch_c, jump_c;

  pipe_ctrl_decode #(.OP_W(OP_W), .EN_EXT(EN_EXT)) u_decode (
    .op_i      (bus.op_i),
    .word_c    (word_c),
    .legal_c   (legal_c),
    .uses_rt_c (uses_rt_c),
    .is_beq_c  (is_beq_c),
    .is_bne_c  (is_bne_c),
    .is_j_c    (is_j_c)
  );

  // Load in EX writing a register the ID instruction reads ($0 never hazards).
  assign hazard_c = bus.valid_i & bus.ex_memread_i & (bus.ex_rt_i != RA_W'(0)) &
                    ((bus.ex_rt_i == bus.rs_i) | (uses_rt_c & (bus.ex_rt_i == bus.rt_i)));

  always_comb begin
    state_d       = state_q;
    stall_cnt_d   = stall_cnt_q;
    ctrl_d        = ctrl_q;
    ctrl_valid_d  = ctrl_valid_q;
    illegal_d     = 1'b0;
    illegal_cnt_d = illegal_cnt_q;
    pc_write_c    = 1'b0;
    branch_c      = 1'b0;
    jump_c        = 1'b0;
    if (!bus.hold_i) begin
      case (state_q)
        ST_RUN: begin
          if (hazard_c) begin
            ctrl_d       = CW_NOP;
            ctrl_valid_d = 1'b0;
            if (STALL_CYCLES > 1) begin
              state_d     = ST_STALL;
              stall_cnt_d = STALL_CNT_W'(STALL_CYCLES - 1);
            end
          end else begin
            pc_write_c   = 1'b1;
            ctrl_d       = bus.valid_i ? word_c : CW_NOP;
            ctrl_valid_d = bus.valid_i & legal_c;
            illegal_d    = bus.valid_i & ~legal_c;
            branch_c     = bus.valid_i & ((is_beq_c & bus.br_eq_i) | (is_bne_c & ~bus.br_eq_i));
            jump_c       = bus.valid_i & is_j_c;
            if (illegal_d && (illegal_cnt_q != '1)) begin
              illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_STALL: begin
          ctrl_d       = CW_NOP;
          ctrl_valid_d = 1'b0;
          stall_cnt_d  = stall_cnt_q - STALL_CNT_W'(1);
          if (stall_cnt_q == STALL_CNT_W'(1)) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= ST_RUN;
      stall_cnt_q   <= '0;
      ctrl_q        <= '0;
      ctrl_valid_q  <= 1'b0;
      illegal_q     <= 1'b0;
      illegal_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      stall_cnt_q   <= stall_cnt_d;
      ctrl_q        <= ctrl_d;
      ctrl_valid_q  <= ctrl_valid_d;
      illegal_q     <= illegal_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign bus.ctrl_o        = ctrl_q;
  assign bus.ctrl_valid_o  = ctrl_valid_q;
  assign bus.illegal_o     = illegal_q;
  assign bus.illegal_cnt_o = illegal_cnt_q;
  assign bus.pc_write_o    = pc_write_c;
  assign bus.ifid_write_o  = pc_write_c;
  assign bus.branch_o      = branch_c;
  assign bus.jump_o        = jump_c;
  assign bus.ifid_flush_o  = branch_c | jump_c;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: two instances (2-cycle stall + extended ops,
// 1-cycle stall + base ops), expected outputs queued per cycle and checked by a monitor.
module tb_pipe_ctrl_unit;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.OP_W(6), .RA_W(5), .CNT_W(8)) a_if ();
  pipe_ctrl_if #(.OP_W(6), .RA_W(5), .CNT_W(8)) b_if ();

  pipe_ctrl_unit #(.OP_W(6), .RA_W(5), .STALL_CYCLES(2), .CNT_W(8), .EN_EXT(1'b1)) dut_a (
    .clk_i(clk), .rst_i(rst_n), .bus(a_if.slave));
  pipe_ctrl_unit #(.OP_W(6), .RA_W(5), .STALL_CYCLES(1), .CNT_W(8), .EN_EXT(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst_n), .bus(b_if.slave));

  typedef struct {
    string      nm;
    bit         sel;
    logic [7:0] ctrl;
    logic       cv;
    logic       ill;
    logic [7:0] cnt;
    logic       pcw;
    logic       br;
    logic       j;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   total = 0;
  int   bad   = 0;
  bit   cur_sel = 1'b0;

  task automatic chk(input string nm, input string f, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s %s: got %0h want %0h", nm, f, act, want);
    end
  endtask

  // Drive one cycle of inputs just after the edge; the unselected DUT idles.
  task automatic drv(input bit sel, input bit rst, input bit v, input logic [5:0] op,
                     input logic [4:0] rs, input logic [4:0] rt, input bit mr,
                     input logic [4:0] exr, input bit beq, input bit hold);
    @(posedge clk);
    #1;
    cur_sel = sel;
    rst_n   = rst;
    a_if.valid_i = v & ~sel;   b_if.valid_i = v & sel;
    a_if.ex_memread_i = mr & ~sel; b_if.ex_memread_i = mr & sel;
    a_if.hold_i  = hold & ~sel; b_if.hold_i  = hold & sel;
    a_if.op_i = op;   b_if.op_i = op;
    a_if.rs_i = rs;   b_if.rs_i = rs;
    a_if.rt_i = rt;   b_if.rt_i = rt;
    a_if.ex_rt_i = exr; b_if.ex_rt_i = exr;
    a_if.br_eq_i = beq; b_if.br_eq_i = beq;
  endtask

  task automatic ex(input string nm, input logic [7:0] ctrl, input bit cv, input bit ill,
                    input int cnt, input bit pcw, input bit br, input bit j);
    exp_t e;
    e.nm = nm; e.sel = cur_sel; e.ctrl = ctrl; e.cv = cv; e.ill = ill;
    e.cnt = 8'(cnt); e.pcw = pcw; e.br = br; e.j = j;
    sb.push_back(e);
  endtask

  // Monitor: one expectation per cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      me = sb.pop_front();
      chk(me.nm, "ctrl",  me.sel ? b_if.ctrl_o        : a_if.ctrl_o,        me.ctrl);
      chk(me.nm, "cv",    me.sel ? b_if.ctrl_valid_o  : a_if.ctrl_valid_o,  me.cv);
      chk(me.nm, "ill",   me.sel ? b_if.illegal_o     : a_if.illegal_o,     me.ill);
      chk(me.nm, "cnt",   me.sel ? b_if.illegal_cnt_o : a_if.illegal_cnt_o, me.cnt);
      chk(me.nm, "pcw",   me.sel ? b_if.pc_write_o    : a_if.pc_write_o,    me.pcw);
      chk(me.nm, "ifidw", me.sel ? b_if.ifid_write_o  : a_if.ifid_write_o,  me.pcw);
      chk(me.nm, "br",    me.sel ? b_if.branch_o      : a_if.branch_o,      me.br);
      chk(me.nm, "jmp",   me.sel ? b_if.jump_o        : a_if.jump_o,        me.j);
      chk(me.nm, "flush", me.sel ? b_if.ifid_flush_o  : a_if.ifid_flush_o,  me.br | me.j);
    end
  end

  initial begin
    a_if.valid_i = 0; a_if.op_i = 0; a_if.rs_i = 0; a_if.rt_i = 0;
    a_if.ex_memread_i = 0; a_if.ex_rt_i = 0; a_if.br_eq_i = 0; a_if.hold_i = 0;
    b_if.valid_i = 0; b_if.op_i = 0; b_if.rs_i = 0; b_if.rt_i = 0;
    b_if.ex_memread_i = 0; b_if.ex_rt_i = 0; b_if.br_eq_i = 0; b_if.hold_i = 0;
    repeat (2) @(posedge clk);

    // Expected registered values reflect the previous line's inputs.
    drv(0,1,0,OP_R,0,0,0,0,0,0);     ex("rst_state",   8'h00,0,0,0,1,0,0);
    drv(0,1,1,OP_R,3,4,0,0,0,0);     ex("add_issue",   8'h00,0,0,0,1,0,0);
    drv(0,1,1,OP_LW,1,2,0,0,0,0);    ex("add_word",    8'h85,1,0,0,1,0,0);
    drv(0,1,1,OP_R,2,5,1,2,0,0);     ex("lw_word_hz",  8'he8,1,0,0,0,0,0);
    drv(0,1,1,OP_R,2,5,0,0,0,0);     ex("stall1",      8'h00,0,0,0,0,0,0);
    drv(0,1,1,OP_R,2,5,0,0,0,0);     ex("stall2",      8'h00,0,0,0,1,0,0);
    drv(0,1,0,OP_R,0,0,0,0,0,0);     ex("after_stall", 8'h85,1,0,0,1,0,0);
    drv(0,1,1,OP_R,0,0,1,0,0,0);     ex("zero_rt_nohz",8'h00,0,0,0,1,0,0);
    drv(0,1,0,OP_R,0,0,0,0,0,0);     ex("zero_rt_word",8'h85,1,0,0,1,0,0);
    drv(0,1,1,OP_SW,7,9,1,9,0,0);    ex("sw_rt_hz",    8'h00,0,0,0,0,0,0);
    drv(0,1,1,OP_SW,7,9,0,0,0,0);    ex("sw_stall",    8'h00,0,0,0,0,0,0);
    drv(0,1,1,OP_SW,7,9,0,0,0,0);    ex("sw_issue",    8'h00,0,0,0,1,0,0);
    drv(0,1,1,OP_ADDI,1,9,1,9,0,0);  ex("addi_no_rt",  8'h18,1,0,0,1,0,0);
    drv(0,1,1,OP_BEQ,1,1,0,0,1,0);   ex("beq_taken",   8'h88,1,0,0,1,1,0);
    drv(0,1,1,OP_BNE,1,1,0,0,1,0);   ex("bne_eq",      8'h02,1,0,0,1,0,0);
    drv(0,1,1,OP_BNE,1,2,0,0,0,0);   ex("bne_ne",      8'h02,1,0,0,1,1,0);
    drv(0,1,1,OP_J,0,0,0,0,0,0);     ex("j_taken",     8'h02,1,0,0,1,0,1);
    drv(0,1,0,OP_BEQ,1,1,0,0,1,0);   ex("beq_invalid", 8'h00,1,0,0,1,0,0);
    drv(0,1,1,OP_BAD,0,0,0,0,0,0);   ex("bad_issue",   8'h00,0,0,0,1,0,0);
    drv(0,1,0,OP_R,0,0,0,0,0,0);     ex("bad_pulse",   8'h00,0,1,1,1,0,0);
    drv(0,1,1,OP_R,4,0,1,4,0,0);     ex("hz_for_hold", 8'h00,0,0,1,0,0,0);
    drv(0,1,1,OP_R,4,0,0,0,0,1);     ex("hold_stall1", 8'h00,0,0,1,0,0,0);
    drv(0,1,1,OP_R,4,0,0,0,0,1);     ex("hold_stall2", 8'h00,0,0,1,0,0,0);
    drv(0,1,1,OP_R,4,0,0,0,0,0);     ex("stall_resume",8'h00,0,0,1,0,0,0);
    drv(0,1,1,OP_R,4,0,0,0,0,0);     ex("run_again",   8'h00,0,0,1,1,0,0);
    drv(0,1,0,OP_R,0,0,0,0,0,0);     ex("hold_pre",    8'h85,1,0,1,1,0,0);
    drv(0,1,1,OP_BEQ,1,1,0,0,1,1);   ex("hold_beq",    8'h00,0,0,1,0,0,0);
    drv(0,1,1,OP_BAD,0,0,0,0,0,1);   ex("hold_bad",    8'h00,0,0,1,0,0,0);
    drv(0,1,0,OP_R,0,0,0,0,0,0);     ex("hold_nocount",8'h00,0,0,1,1,0,0);
    drv(0,1,1,OP_R,3,3,0,0,0,0);     ex("pre_hold_wd", 8'h00,0,0,1,1,0,0);
    drv(0,1,0,OP_R,0,0,0,0,0,1);     ex("hold_word1",  8'h85,1,0,1,0,0,0);
    drv(0,1,0,OP_R,0,0,0,0,0,1);     ex("hold_word2",  8'h85,1,0,1,0,0,0);
    drv(0,1,0,OP_R,0,0,0,0,0,0);     ex("hold_word3",  8'h85,1,0,1,1,0,0);
    drv(0,1,0,OP_R,0,0,0,0,0,0);     ex("word_clear",  8'h00,0,0,1,1,0,0);
    drv(0,1,1,OP_BAD,6,0,1,6,0,0);   ex("bad_hz",      8'h00,0,0,1,0,0,0);
    drv(0,1,1,OP_BAD,6,0,0,0,0,0);   ex("bad_stall",   8'h00,0,0,1,0,0,0);
    drv(0,1,1,OP_BAD,6,0,0,0,0,0);   ex("bad_run",     8'h00,0,0,1,1,0,0);
    drv(0,1,0,OP_R,0,0,0,0,0,0);     ex("bad_once",    8'h00,0,1,2,1,0,0);
    drv(0,1,1,OP_R,3,1,0,0,0,0);     ex("pulse_end",   8'h00,0,0,2,1,0,0);
    drv(0,1,1,OP_R,3,1,1,3,0,0);     ex("pre_rst_hz",  8'h85,1,0,2,0,0,0);
    drv(0,0,0,OP_R,0,0,0,0,0,0);     ex("async_rst",   8'h00,0,0,0,1,0,0);
    drv(0,1,0,OP_R,0,0,0,0,0,0);     ex("rst_release", 8'h00,0,0,0,1,0,0);

    drv(1,1,1,OP_J,0,0,0,0,0,0);     ex("b_j_illegal", 8'h00,0,0,0,1,0,0);
    drv(1,1,0,OP_R,0,0,0,0,0,0);     ex("b_j_pulse",   8'h00,0,1,1,1,0,0);
    drv(1,1,1,OP_ADDI,1,2,0,0,0,0);  ex("b_addi",      8'h00,0,0,1,1,0,0);
    drv(1,1,1,OP_R,8,9,0,0,0,0);     ex("b_addi_pulse",8'h00,0,1,2,1,0,0);
    drv(1,1,1,OP_R,8,9,1,8,0,0);     ex("b_hz1",       8'h85,1,0,2,0,0,0);
    drv(1,1,1,OP_R,8,9,1,8,0,0);     ex("b_hz_again",  8'h00,0,0,2,0,0,0);
    drv(1,1,1,OP_R,8,9,0,0,0,0);     ex("b_release",   8'h00,0,0,2,1,0,0);
    drv(1,1,1,OP_BNE,1,2,0,0,0,0);   ex("b_bne_ill",   8'h85,1,0,2,1,0,0);
    drv(1,1,0,OP_R,0,0,0,0,0,0);     ex("b_bne_pulse", 8'h00,0,1,3,1,0,0);

    for (int i = 0; i < 300; i++) begin
      drv(1,1,1,OP_BAD,0,0,0,0,0,0);
      ex("b_sat", 8'h00, 0, (i > 0), (i == 0) ? 3 : ((3 + i) > 255 ? 255 : 3 + i), 1, 0, 0);
    end
    drv(1,1,0,OP_R,0,0,0,0,0,0);     ex("b_sat_end",   8'h00,0,1,255,1,0,0);
    drv(1,1,0,OP_R,0,0,0,0,0,0);     ex("b_sat_stay",  8'h00,0,0,255,1,0,0);

    for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
